mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 32-bit memory port between two requesters: port 0 is fetch, port 1 is load/store.
//  Round-robin arbitration with a single-transaction handshake and a timeout abort.
//  Drives the select of a 32-bit 2:1 operand mux (mux2_1) that steers address/wdata to the port.
//  Sits between the pipeline's IF/MEM stages and the unified memory interface.
// PARAMETERS
//  WIDTH    32  data/address width
//  TIMEOUT  16  cycles to wait for mem_ready before abort; 0 = never abort
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req0/req1  in   1      request; held with operands stable until done or err for that port
//  addr0/1    in   WIDTH  request address
//  wdata0/1   in   WIDTH  write data
//  we0/we1    in   1      1 = write, 0 = read
//  gnt0/gnt1  out  1      high while that port owns the memory port
//  done0/1    out  1      1-cycle pulse; transaction completed, rdata valid this cycle
//  err0/1     out  1      1-cycle pulse; transaction aborted by timeout
//  sel        out  1      mux select: 0 = port 0 operands, 1 = port 1 operands
//  mem_valid  out  1      transaction active on the memory port
//  mem_we     out  1      registered copy of the winner's we
//  mem_ready  in   1      memory completion strobe
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, last=1 (port 0 wins first tie); all outputs 0, timer=0.
//  Reset mid-transaction aborts immediately with no done/err. Memory must tolerate the dropped mem_valid.
//  FSM states: IDLE, BUSY0, BUSY1. All outputs are decoded from registered state, no comb req->gnt path.
//  IDLE:
//   - Only req0 high -> BUSY0. Only req1 high -> BUSY1.
//   - Both high -> port != last wins.
//   - Grant seen the cycle after req: sel, gnt_n, mem_valid, mem_we all assert together.
//  BUSYn:
//   - Outputs: gnt_n=1, mem_valid=1, sel=n; timer increments each cycle.
//   - mem_ready=1: done_n pulses this cycle, last<=n, timer<=0.
//     Then go to BUSY(other) if req(other) is high, else IDLE. Back-to-back switch costs 0 idle cycles.
//   - The same port is never regranted in its done cycle. It must drop req for 1 cycle or be
//     re-sampled in IDLE.
//   - Timeout: TIMEOUT!=0 and timer==TIMEOUT-1 and !mem_ready -> err_n pulses, last<=n, go IDLE.
//   - mem_ready in the timeout cycle wins: done, not err.
//  req_n deasserted while BUSYn is a protocol violation; the arbiter ignores it and completes normally.
//  Widths: timer is $clog2(TIMEOUT+1) bits, saturating, never wraps.
//  The mux data path is combinational; sel is the only control into it.
// STRUCTURE
//  arb_pkg: typedef enum logic[1:0] {IDLE,BUSY0,BUSY1} arb_state_t; localparam WIDTH_DEF=32.
//  Sub-module: two mux2_1 instances (addr, wdata) controlled by sel; FSM + timer in this module.
// TESTING
//  1 req0 alone, mem_ready 3 cycles after gnt0 -> gnt0 cycle 1, done0 cycle 4, sel=0, IDLE after.
//  2 req0&req1 from reset, ready=1 always -> gnt0, then gnt1 back-to-back, then gnt0 alternating.
//  3 req1 held while port 0 busy, ready after 2 cycles -> done0 and switch to BUSY1 same edge, sel=1.
//  4 TIMEOUT=16, never ready -> err1 pulse on the 16th busy cycle, no done1, IDLE, next tie goes to 0.
//  5 mem_ready on the timeout cycle -> done pulses, err stays 0.
//  6 rst_n low mid-BUSY1 -> all outputs 0 asynchronously, sel=0; after release req1 alone -> gnt1 at cycle 1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the memory-port arbiter.
//  arb_state_t : arbiter FSM state (IDLE, BUSY0 = fetch owns port, BUSY1 = load/store owns port)
//  WIDTH_DEF   : default address/data width
package arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam int WIDTH_DEF = 32;
endpackage

// File: rtl/mux2_1.sv
// 2:1 operand mux steering one requester's operands onto the memory port.
//  sel : 0 = in0, 1 = in1
//  in0 / in1 : WIDTH-bit operands
//  y   : selected operand (purely combinational)
module mux2_1 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? in1 : in0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and
// load/store (port 1), with single-transaction handshake and timeout abort.
//  clk, rst_n            : clock, async active-low reset
//  req/addr/wdata/we 0,1 : per-port request and operands (held until done/err)
//  gnt0/1                : port owns the memory port
//  done0/1, err0/1       : 1-cycle completion / timeout-abort pulses
//  sel                   : operand mux select (0 = port 0, 1 = port 1)
//  mem_valid, mem_we     : memory-side transaction strobe and registered write enable
//  mem_addr, mem_wdata   : muxed operands to the memory port
//  mem_ready             : memory completion strobe
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic             sel,
  output logic             mem_valid,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready
);
  // TIMEOUT=0 would give a zero-width timer; keep at least one bit.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t    state, state_nxt;
  logic          last;
  logic [TW-1:0] timer;
  logic          mem_we_q;
  logic          busy0, busy1, tmo_hit;

  assign busy0   = (state == BUSY0);
  assign busy1   = (state == BUSY1);
  assign tmo_hit = (TIMEOUT != 0) && (timer == TLAST);

  // Everything below depends only on registered state (and mem_ready for
  // the completion pulses), so there is no combinational req->gnt path.
  assign gnt0      = busy0;
  assign gnt1      = busy1;
  assign sel       = busy1;
  assign mem_valid = busy0 | busy1;
  assign mem_we    = mem_we_q;
  // mem_ready in the timeout cycle counts as completion, not abort.
  assign done0     = busy0 & mem_ready;
  assign done1     = busy1 & mem_ready;
  assign err0      = busy0 & ~mem_ready & tmo_hit;
  assign err1      = busy1 & ~mem_ready & tmo_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      // On a tie the port that did not go last wins.
      IDLE:    if (req0 && (!req1 || last)) state_nxt = BUSY0;
               else if (req1)               state_nxt = BUSY1;
      // Completion hands straight to the other port if it waits; the
      // finishing port is never regranted in its own done cycle.
      BUSY0:   if (mem_ready)    state_nxt = req1 ? BUSY1 : IDLE;
               else if (tmo_hit) state_nxt = IDLE;
      BUSY1:   if (mem_ready)    state_nxt = req0 ? BUSY0 : IDLE;
               else if (tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      timer    <= '0;
      mem_we_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((busy0 || busy1) && (mem_ready || tmo_hit))
        last <= busy1;
      if (!(busy0 || busy1) || mem_ready || tmo_hit)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
      // Capture the winner's we on every ownership change.
      if (state_nxt != state)
        mem_we_q <= (state_nxt == BUSY0) ? we0 :
                    (state_nxt == BUSY1) ? we1 : 1'b0;
    end
  end

  mux2_1 #(.WIDTH(WIDTH)) u_mux_addr (
    .sel(sel), .in0(addr0), .in1(addr1), .y(mem_addr)
  );

  mux2_1 #(.WIDTH(WIDTH)) u_mux_wdata (
    .sel(sel), .in0(wdata0), .in1(wdata1), .y(mem_wdata)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT = 16).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, mem_ready;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1, sel, mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [8:0]  obs;
  int          tests = 0;
  int          fails = 0;

  mem_port_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .sel(sel), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // {gnt0,gnt1,done0,done1,err0,err1,sel,mem_valid,mem_we}
  assign obs = {gnt0, gnt1, done0, done1, err0, err1, sel, mem_valid, mem_we};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_ready = 0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; mem_ready = 1;
    tick();
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 9'b0);
    end
    do_reset();
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", obs, 9'b0);
    end
  endtask

  task automatic test_single_req0();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 32'h1000_0040; wdata0 = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL single_c0: got %b expected %b", obs, 9'b0);
    end
    tick();  // cycle 1
    tests++;
    if (obs !== 9'b100000011 || mem_addr !== 32'h1000_0040 || mem_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_gnt: got %b addr %h wdata %h expected %b addr 10000040 wdata deadbeef",
               obs, mem_addr, mem_wdata, 9'b100000011);
    end
    tick(); tick(); tick();  // cycle 4
    mem_ready = 1; req0 = 0;
    #1;
    tests++;
    if (obs !== 9'b101000011) begin
      fails++;
      $display("FAIL single_done: got %b expected %b", obs, 9'b101000011);
    end
    tick();  // cycle 5
    mem_ready = 0;
    #1;
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL single_idle: got %b expected %b", obs, 9'b0);
    end
  endtask

  task automatic test_alternate();
    logic [8:0] exp_v;
    do_reset();
    req0 = 1; req1 = 1; mem_ready = 1;
    addr0 = 32'hA0; addr1 = 32'hB1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) req0 = 0;
      if (c == 4) req1 = 0;
      #1;
      exp_v = (c % 2 == 1) ? 9'b101000010 : 9'b010100110;
      tests++;
      if (obs !== exp_v || mem_addr !== ((c % 2 == 1) ? 32'hA0 : 32'hB1)) begin
        fails++;
        $display("FAIL alternate_c%0d: got %b addr %h expected %b", c, obs, mem_addr, exp_v);
      end
    end
    tick();
    mem_ready = 0;
    #1;
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL alternate_idle: got %b expected %b", obs, 9'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 32'h10;
    tick();  // cycle 1: BUSY0
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h5555_AAAA;
    tick();  // cycle 2
    tick();  // cycle 3
    mem_ready = 1; req0 = 0;
    #1;
    tests++;
    if (obs !== 9'b101000010) begin
      fails++;
      $display("FAIL b2b_done0: got %b expected %b", obs, 9'b101000010);
    end
    tick();  // cycle 4: BUSY1 with no idle gap
    mem_ready = 0;
    #1;
    tests++;
    if (obs !== 9'b010000111 || mem_addr !== 32'h20 || mem_wdata !== 32'h5555_AAAA) begin
      fails++;
      $display("FAIL b2b_gnt1: got %b addr %h wdata %h expected %b addr 20 wdata 5555aaaa",
               obs, mem_addr, mem_wdata, 9'b010000111);
    end
    mem_ready = 1; req1 = 0;
    tick();
    mem_ready = 0;
    #1;
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL b2b_idle: got %b expected %b", obs, 9'b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req1 = 1; we1 = 0;
    for (int c = 1; c <= 15; c++) tick();  // cycle 15
    tests++;
    if (obs !== 9'b010000110) begin
      fails++;
      $display("FAIL timeout_c15: got %b expected %b", obs, 9'b010000110);
    end
    tick();  // cycle 16
    req0 = 1;
    #1;
    tests++;
    if (obs !== 9'b010001110) begin
      fails++;
      $display("FAIL timeout_err1: got %b expected %b", obs, 9'b010001110);
    end
    tick();  // cycle 17: IDLE after abort
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL timeout_idle: got %b expected %b", obs, 9'b0);
    end
    tick();  // cycle 18: tie goes to port 0
    mem_ready = 1; req0 = 0; req1 = 0;
    #1;
    tests++;
    if (obs !== 9'b101000010) begin
      fails++;
      $display("FAIL timeout_tie: got %b expected %b", obs, 9'b101000010);
    end
    tick();
    mem_ready = 0;
  endtask

  task automatic test_ready_on_timeout();
    do_reset();
    req0 = 1;
    for (int c = 1; c <= 16; c++) tick();  // cycle 16, timer at limit
    mem_ready = 1; req0 = 0;
    #1;
    tests++;
    if (obs !== 9'b101000010) begin
      fails++;
      $display("FAIL ready_at_timeout: got %b expected %b", obs, 9'b101000010);
    end
    tick();
    mem_ready = 0;
    #1;
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL ready_at_timeout_idle: got %b expected %b", obs, 9'b0);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req1 = 1; we1 = 1;
    tick(); tick();  // cycle 2, BUSY1
    tests++;
    if (obs !== 9'b010000111) begin
      fails++;
      $display("FAIL midrst_busy: got %b expected %b", obs, 9'b010000111);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL midrst_async: got %b expected %b", obs, 9'b0);
    end
    #1;
    rst_n = 1'b1;
    #1;
    tests++;
    if (obs !== 9'b0) begin
      fails++;
      $display("FAIL midrst_release: got %b expected %b", obs, 9'b0);
    end
    tick();  // first edge after release
    tests++;
    if (obs !== 9'b010000111) begin
      fails++;
      $display("FAIL midrst_regrant: got %b expected %b", obs, 9'b010000111);
    end
    req1 = 0; mem_ready = 1;
    tick();
    mem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_alternate();
    test_back_to_back();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
